// File: rtl/arm_code_writer.sv
// Output-side sink for the JIT state machine: buffers 32-bit ARM instruction words
// and writes them little-endian, one byte per cycle, into the byte-wide code RAM.
module arm_code_writer #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_word,
  output logic              waiting,
  input  logic              flush,
  output logic              oram_we,
  output logic [ADDR_W-1:0] oram_addr,
  output logic [7:0]        oram_data,
  output logic [ADDR_W-1:0] write_ptr,
  output logic [15:0]       words_emitted,
  output logic              done,
  output logic              overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  // One spare pointer bit so a completely filled RAM does not alias back to address 0.
  localparam logic [ADDR_W:0] BASE_PTR  = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'((1 << ADDR_W) - 4);

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [15:0]       emitted_q, emitted_d;
  logic              overflow_q, overflow_d;
  logic              flush_pending_q, flush_pending_d;
  logic              done_q, done_d;
  logic              oram_we_q, oram_we_d;
  logic [ADDR_W-1:0] oram_addr_q, oram_addr_d;
  logic [7:0]        oram_data_q, oram_data_d;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [31:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic        push;
  logic        pop;
  logic        fits;
  logic [31:0] head;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Registered state only, so the state machine never sees a loop through in_valid.
  assign waiting = (count_q == FULL_CNT) || overflow_q;

  always_comb begin
    state_d         = state_q;
    byte_idx_d      = byte_idx_q;
    ptr_d           = ptr_q;
    emitted_d       = emitted_q;
    overflow_d      = overflow_q;
    oram_we_d       = 1'b0;
    oram_addr_d     = oram_addr_q;
    oram_data_d     = oram_data_q;
    mem_d           = mem_q;
    rd_d            = rd_q;
    wr_d            = wr_q;
    pop             = 1'b0;
    push            = in_valid && !waiting;
    head            = mem_q[rd_q];
    fits            = (ptr_q <= LAST_WORD);

    unique case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          if (fits && !overflow_q) begin
            state_d     = ST_WRITE;
            byte_idx_d  = 2'd0;
            oram_we_d   = 1'b1;
            oram_addr_d = {ptr_q[ADDR_W-1:2], 2'd0};
            oram_data_d = byte_sel(head, 2'd0);
          end else begin
            overflow_d = 1'b1;
            pop        = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        // Outputs are registered, so the head word is retired on the edge that launches byte 3.
        if (byte_idx_q != 2'd3) begin
          byte_idx_d  = byte_idx_q + 2'd1;
          oram_we_d   = 1'b1;
          oram_addr_d = {ptr_q[ADDR_W-1:2], byte_idx_d};
          oram_data_d = byte_sel(head, byte_idx_d);
          if (byte_idx_q == 2'd2) begin
            pop       = 1'b1;
            ptr_d     = ptr_q + (ADDR_W+1)'(4);
            emitted_d = emitted_q + 16'd1;
          end
        end else if ((count_q != '0) && fits && !overflow_q) begin
          byte_idx_d  = 2'd0;
          oram_we_d   = 1'b1;
          oram_addr_d = {ptr_q[ADDR_W-1:2], 2'd0};
          oram_data_d = byte_sel(head, 2'd0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      mem_d[wr_q] = in_word;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_d = rd_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    flush_pending_d = flush_pending_q || flush;
    done_d          = flush_pending_d && (count_d == '0) && (state_d == ST_IDLE);
    if (done_d) begin
      flush_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      byte_idx_q      <= 2'd0;
      ptr_q           <= BASE_PTR;
      emitted_q       <= 16'd0;
      overflow_q      <= 1'b0;
      flush_pending_q <= 1'b0;
      done_q          <= 1'b0;
      oram_we_q       <= 1'b0;
      oram_addr_q     <= '0;
      oram_data_q     <= 8'd0;
      mem_q           <= '{default: '0};
      rd_q            <= '0;
      wr_q            <= '0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      byte_idx_q      <= byte_idx_d;
      ptr_q           <= ptr_d;
      emitted_q       <= emitted_d;
      overflow_q      <= overflow_d;
      flush_pending_q <= flush_pending_d;
      done_q          <= done_d;
      oram_we_q       <= oram_we_d;
      oram_addr_q     <= oram_addr_d;
      oram_data_q     <= oram_data_d;
      mem_q           <= mem_d;
      rd_q            <= rd_d;
      wr_q            <= wr_d;
      count_q         <= count_d;
    end
  end

  assign oram_we       = oram_we_q;
  assign oram_addr     = oram_addr_q;
  assign oram_data     = oram_data_q;
  assign write_ptr     = ptr_q[ADDR_W-1:0];
  assign words_emitted = emitted_q;
  assign done          = done_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_arm_code_writer.sv
// Bench for arm_code_writer: scoreboard of expected code-RAM byte writes plus
// per-scenario timing and status checks on two parameterisations.
module tb_arm_code_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        in_valid, flush, waiting, oram_we, done, overflow;
  logic [31:0] in_word;
  logic [11:0] oram_addr, write_ptr;
  logic [7:0]  oram_data;
  logic [15:0] words_emitted;

  logic        o_in_valid, o_flush, o_waiting, o_oram_we, o_done, o_overflow;
  logic [31:0] o_in_word;
  logic [3:0]  o_oram_addr, o_write_ptr;
  logic [7:0]  o_oram_data;
  logic [15:0] o_words_emitted;

  arm_code_writer #(.ADDR_W(12), .FIFO_DEPTH(4), .BASE_ADDR('h100)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_word(in_word), .waiting(waiting),
    .flush(flush), .oram_we(oram_we), .oram_addr(oram_addr), .oram_data(oram_data),
    .write_ptr(write_ptr), .words_emitted(words_emitted), .done(done), .overflow(overflow)
  );

  arm_code_writer #(.ADDR_W(4), .FIFO_DEPTH(4), .BASE_ADDR(0)) u_ovf (
    .clk(clk), .reset(reset), .in_valid(o_in_valid), .in_word(o_in_word), .waiting(o_waiting),
    .flush(o_flush), .oram_we(o_oram_we), .oram_addr(o_oram_addr), .oram_data(o_oram_data),
    .write_ptr(o_write_ptr), .words_emitted(o_words_emitted), .done(o_done), .overflow(o_overflow)
  );

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  oexp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   last_we_cyc = 0;
  logic saw_waiting = 1'b0;
  logic [11:0] exp_ptr = 12'h100;
  logic [15:0] exp_emitted = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t e;
    wr_t oe;
    if (reset) begin
      if (waiting) saw_waiting = 1'b1;
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (oram_we) begin
        last_we_cyc = cyc;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          failures = failures + 1;
          $display("FAIL oram_write: got unexpected write addr=%h data=%h, expected no write", oram_addr, oram_data);
        end else begin
          e = exp_q.pop_front();
          if (oram_addr !== e.addr || oram_data !== e.data) begin
            failures = failures + 1;
            $display("FAIL oram_write: got addr=%h data=%h, expected addr=%h data=%h",
                     oram_addr, oram_data, e.addr, e.data);
          end
        end
      end
      if (o_oram_we) begin
        checks = checks + 1;
        if (oexp_q.size() == 0) begin
          failures = failures + 1;
          $display("FAIL ovf_write: got unexpected write addr=%h data=%h, expected no write", o_oram_addr, o_oram_data);
        end else begin
          oe = oexp_q.pop_front();
          if ({8'h00, o_oram_addr} !== oe.addr || o_oram_data !== oe.data) begin
            failures = failures + 1;
            $display("FAIL ovf_write: got addr=%h data=%h, expected addr=%h data=%h",
                     o_oram_addr, o_oram_data, oe.addr, oe.data);
          end
        end
      end
    end
  end

  task automatic add_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{addr: exp_ptr + 12'(i), data: w[8*i +: 8]});
    end
    exp_ptr     = exp_ptr + 12'd4;
    exp_emitted = exp_emitted + 16'd1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push_word(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_word  = w;
    @(negedge clk);
    while (waiting && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 64) begin
      failures++;
      $display("FAIL push_timeout: waiting=%b after %0d cycles, expected 0", waiting, n);
    end else begin
      add_word(w);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d bytes, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_word = '0; flush = 1'b0;
    o_in_valid = 1'b0; o_in_word = '0; o_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (waiting !== 1'b0) begin failures++; $display("FAIL rst_waiting: got %b expected 0", waiting); end
    checks++; if (oram_we !== 1'b0) begin failures++; $display("FAIL rst_we: got %b expected 0", oram_we); end
    checks++; if (oram_addr !== 12'h000) begin failures++; $display("FAIL rst_addr: got %h expected 000", oram_addr); end
    checks++; if (oram_data !== 8'h00) begin failures++; $display("FAIL rst_data: got %h expected 00", oram_data); end
    checks++; if (write_ptr !== 12'h100) begin failures++; $display("FAIL rst_write_ptr: got %h expected 100", write_ptr); end
    checks++; if (words_emitted !== 16'd0) begin failures++; $display("FAIL rst_words: got %0d expected 0", words_emitted); end
    checks++; if (done !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL rst_done_ovf: got %b%b expected 00", done, overflow); end
    checks++; if (o_write_ptr !== 4'h0 || o_overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf_inst: got ptr=%h ovf=%b expected 0/0", o_write_ptr, o_overflow); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_ptr = 12'h100;
    exp_emitted = 16'd0;
  endtask

  task automatic test_single_word();
    in_valid = 1'b1;
    in_word  = 32'hE3A00001;
    add_word(32'hE3A00001);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (oram_we !== 1'b0) begin failures++; $display("FAIL single_lat0: got we=%b expected 0", oram_we); end
    @(negedge clk);
    checks++; if (oram_we !== 1'b1 || oram_addr !== 12'h100) begin failures++; $display("FAIL single_lat1: got we=%b addr=%h expected 1/100", oram_we, oram_addr); end
    wait_drain();
    checks++; if (write_ptr !== 12'h104) begin failures++; $display("FAIL single_ptr: got %h expected 104", write_ptr); end
    checks++; if (words_emitted !== 16'd1) begin failures++; $display("FAIL single_words: got %0d expected 1", words_emitted); end
  endtask

  task automatic test_backpressure();
    saw_waiting = 1'b0;
    for (int i = 0; i < 6; i++) push_word($urandom());
    wait_drain();
    checks++; if (saw_waiting !== 1'b1) begin failures++; $display("FAIL bp_waiting: got %b expected 1", saw_waiting); end
    checks++; if (words_emitted !== exp_emitted) begin failures++; $display("FAIL bp_words: got %0d expected %0d", words_emitted, exp_emitted); end
    checks++; if (write_ptr !== exp_ptr) begin failures++; $display("FAIL bp_ptr: got %h expected %h", write_ptr, exp_ptr); end
  endtask

  task automatic test_flush();
    logic [31:0] w1, w2;
    int f_cyc;
    w1 = $urandom();
    w2 = $urandom();
    done_cnt = 0;
    in_valid = 1'b1; in_word = w1; add_word(w1);
    @(posedge clk);
    #1;
    in_word = w2; flush = 1'b1; add_word(w2);
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wait_drain();
    repeat (4) @(posedge clk);
    #1;
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL flush_count: got %0d done pulses expected 1", done_cnt); end
    checks++; if (done_cyc !== last_we_cyc + 1) begin failures++; $display("FAIL flush_timing: got done at %0d expected %0d", done_cyc, last_we_cyc + 1); end
    done_cnt = 0;
    flush = 1'b1;
    f_cyc = cyc;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done_cnt !== 1 || done_cyc !== f_cyc + 1) begin failures++; $display("FAIL flush_empty: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_cyc, f_cyc + 1); end
  endtask

  task automatic test_reset_mid_word();
    int n;
    n = 0;
    in_valid = 1'b1; in_word = $urandom(); add_word(in_word);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    while (!(oram_we === 1'b1 && oram_addr[1:0] == 2'd1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 20) begin failures++; $display("FAIL midrst_byte1: got no byte 1 write, expected one"); end
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    checks++; if (oram_we !== 1'b0) begin failures++; $display("FAIL midrst_we: got %b expected 0", oram_we); end
    checks++; if (oram_addr !== 12'h000 || oram_data !== 8'h00) begin failures++; $display("FAIL midrst_bus: got %h/%h expected 000/00", oram_addr, oram_data); end
    checks++; if (write_ptr !== 12'h100 || words_emitted !== 16'd0) begin failures++; $display("FAIL midrst_state: got ptr=%h words=%0d expected 100/0", write_ptr, words_emitted); end
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_ptr = 12'h100;
    exp_emitted = 16'd0;
    @(posedge clk);
    #1;
    push_word($urandom());
    wait_drain();
    checks++; if (write_ptr !== 12'h104 || words_emitted !== 16'd1) begin failures++; $display("FAIL midrst_restart: got ptr=%h words=%0d expected 104/1", write_ptr, words_emitted); end
  endtask

  task automatic test_push_pop();
    logic [11:0] first;
    logic [31:0] w5;
    int n;
    first = exp_ptr;
    w5 = $urandom();
    n = 0;
    for (int i = 0; i < 4; i++) push_word($urandom());
    in_valid = 1'b1;
    in_word  = w5;
    @(negedge clk);
    while (!(oram_we === 1'b1 && oram_addr == first + 12'd2) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (waiting !== 1'b1) begin failures++; $display("FAIL pp_full: got waiting=%b expected 1", waiting); end
    @(negedge clk);
    checks++; if (waiting !== 1'b0 || oram_addr !== first + 12'd3) begin failures++; $display("FAIL pp_after_pop: got waiting=%b addr=%h expected 0/%h", waiting, oram_addr, first + 12'd3); end
    add_word(w5);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (waiting !== 1'b1) begin failures++; $display("FAIL pp_refull: got waiting=%b expected 1", waiting); end
    wait_drain();
    checks++; if (words_emitted !== exp_emitted || write_ptr !== exp_ptr) begin failures++; $display("FAIL pp_totals: got words=%0d ptr=%h expected %0d/%h", words_emitted, write_ptr, exp_emitted, exp_ptr); end
  endtask

  task automatic test_overflow();
    logic [31:0] w;
    int n;
    for (int i = 0; i < 5; i++) begin
      w = $urandom();
      o_in_valid = 1'b1;
      o_in_word  = w;
      n = 0;
      @(negedge clk);
      while (o_waiting && n < 64) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n >= 64) begin
        failures++;
        $display("FAIL ovf_push_timeout: word %0d waiting=%b expected 0", i, o_waiting);
      end else begin
        if (i < 4) begin
          for (int b = 0; b < 4; b++) oexp_q.push_back('{addr: 12'(4 * i + b), data: w[8*b +: 8]});
        end
        @(posedge clk);
        #1;
      end
      o_in_valid = 1'b0;
    end
    n = 0;
    while (oexp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (oexp_q.size() != 0) begin failures++; $display("FAIL ovf_drain: got %0d pending bytes expected 0", oexp_q.size()); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (o_overflow !== 1'b1 || o_waiting !== 1'b1) begin failures++; $display("FAIL ovf_flags: got ovf=%b waiting=%b expected 1/1", o_overflow, o_waiting); end
    checks++; if (o_words_emitted !== 16'd4) begin failures++; $display("FAIL ovf_words: got %0d expected 4", o_words_emitted); end
    o_in_valid = 1'b1;
    o_in_word  = $urandom();
    repeat (4) @(posedge clk);
    #1;
    o_in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (o_overflow !== 1'b1 || o_waiting !== 1'b1 || o_words_emitted !== 16'd4) begin failures++; $display("FAIL ovf_sticky: got ovf=%b waiting=%b words=%0d expected 1/1/4", o_overflow, o_waiting, o_words_emitted); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_flush();
    test_reset_mid_word();
    test_push_pop();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
